// File: rtl/pdm_dac_pkg.sv
// Shared constants and helpers for the multichannel sigma-delta PDM DAC.
// Integrator sizing, saturation limit and the dither LFSR live here.
package pdm_dac_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois mask for taps 16,14,13,11 (tap t maps to bit t-1)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int int_width(input int dw);
        return dw + 3;
    endfunction

    function automatic longint sat_limit(input int dw);
        return (longint'(1) << (dw + 1)) - 1;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/pdm_dac_mc_if.sv
// Sample/control bus and PDM outputs of the PDM DAC.
// in_valid is a pure load strobe: there is no ready, every cycle with in_valid=1 loads in_data.
interface pdm_dac_mc_if #(
    parameter int NCH = 2,
    parameter int DW  = 16
);
    logic              pdm_ce;
    logic              in_valid;
    logic [NCH*DW-1:0] in_data;
    logic              mute;
    logic              ovl_clr;
    logic [NCH-1:0]    pdm;
    logic [NCH-1:0]    ovl;

    modport master (
        output pdm_ce, in_valid, in_data, mute, ovl_clr,
        input  pdm, ovl
    );

    modport slave (
        input  pdm_ce, in_valid, in_data, mute, ovl_clr,
        output pdm, ovl
    );
endinterface

// File: rtl/pdm_mod_ch.sv
// One channel of the sigma-delta modulator: saturating integrators,
// 1-bit quantiser and sticky overload detection.
module pdm_mod_ch
    import pdm_dac_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ORDER = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              ovl_clr,
    input  logic signed [DW:0] x,
    output logic              pdm,
    output logic              ovl
);
    localparam int IW = int_width(DW);
    localparam logic signed [IW:0] LIM = (IW+1)'(sat_limit(DW));
    localparam logic signed [IW:0] FS  = (IW+1)'(longint'(1) << (DW - 1));

    logic signed [IW-1:0] a1;
    logic signed [IW-1:0] a2;
    logic signed [IW:0]   fb;
    logic signed [IW:0]   s1;
    logic signed [IW:0]   s2;
    logic signed [IW:0]   n1;
    logic signed [IW:0]   n2;
    logic                 c1;
    logic                 c2;
    logic                 q;

    // Sums carry one guard bit beyond the integrator so the clamp sees the true value
    always_comb begin
        fb = pdm ? FS : -FS;
        s1 = (IW+1)'(a1) + (IW+1)'(x) - fb;
        c1 = (s1 > LIM) || (s1 < -LIM);
        if (s1 > LIM)       n1 = LIM;
        else if (s1 < -LIM) n1 = -LIM;
        else                n1 = s1;

        s2 = (IW+1)'(a2) + n1 - fb;
        c2 = (s2 > LIM) || (s2 < -LIM);
        if (s2 > LIM)       n2 = LIM;
        else if (s2 < -LIM) n2 = -LIM;
        else                n2 = s2;

        if (ORDER == 2) begin
            q = ~n2[IW];
        end else begin
            q  = ~n1[IW];
            c2 = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1  <= '0;
            a2  <= '0;
            pdm <= 1'b0;
            ovl <= 1'b0;
        end else begin
            if (ce) begin
                a1  <= n1[IW-1:0];
                a2  <= (ORDER == 2) ? n2[IW-1:0] : '0;
                pdm <= q;
            end
            // A clamp on this step beats a simultaneous clear
            if (ce && (c1 || c2)) ovl <= 1'b1;
            else if (ovl_clr)     ovl <= 1'b0;
        end
    end

endmodule

// File: rtl/pdm_dac_mc.sv
// Multichannel PDM DAC: sample hold registers, mute/dither input mux,
// shared dither LFSR and one modulator per channel.
module pdm_dac_mc
    import pdm_dac_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DW     = 16,
    parameter int ORDER  = 2,
    parameter int DITHER = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    pdm_dac_mc_if.slave        bus
);
    logic signed [DW-1:0] hold [NCH];
    logic [15:0]          lfsr;
    logic [NCH-1:0]       pdm_v;
    logic [NCH-1:0]       ovl_v;

    // Sample load is independent of pdm_ce; the modulator sees the old hold on a shared edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) hold[k] <= '0;
            lfsr <= LFSR_SEED;
        end else begin
            if (bus.in_valid) begin
                for (int k = 0; k < NCH; k++) hold[k] <= bus.in_data[k*DW +: DW];
            end
            if (bus.pdm_ce) lfsr <= lfsr_next(lfsr);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic              dith;
        logic signed [DW:0] x;

        assign dith = (DITHER != 0) && lfsr[k % 16];
        assign x    = (bus.mute ? '0 : (DW+1)'(hold[k])) + (DW+1)'(dith);

        pdm_mod_ch #(
            .DW    (DW),
            .ORDER (ORDER)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .ce      (bus.pdm_ce),
            .ovl_clr (bus.ovl_clr),
            .x       (x),
            .pdm     (pdm_v[k]),
            .ovl     (ovl_v[k])
        );
    end

    assign bus.pdm = pdm_v;
    assign bus.ovl = ovl_v;

endmodule

// File: tb/tb_pdm_dac_mc.sv
// Bench for pdm_dac_mc: two builds (2nd-order undithered, 1st-order dithered)
// driven in lockstep and checked every cycle against an arithmetic model.
module tb_pdm_dac_mc;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam longint LIM = 131071;
    localparam longint FS  = 32768;
    localparam int ORD  [2] = '{2, 1};
    localparam int DITH [2] = '{0, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   mute_r = 1'b0;
    bit   chk_en = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    pdm_dac_mc_if #(.NCH(NCH), .DW(DW)) if0 ();
    pdm_dac_mc_if #(.NCH(NCH), .DW(DW)) if1 ();

    pdm_dac_mc #(.NCH(NCH), .DW(DW), .ORDER(2), .DITHER(0)) u0 (
        .clk (clk), .rst_n (rst_n), .bus (if0.slave)
    );
    pdm_dac_mc #(.NCH(NCH), .DW(DW), .ORDER(1), .DITHER(1)) u1 (
        .clk (clk), .rst_n (rst_n), .bus (if1.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    longint      m_a1 [2][NCH];
    longint      m_a2 [2][NCH];
    bit          m_p  [2][NCH];
    bit          m_o  [2][NCH];
    longint      m_hold [NCH];
    int unsigned m_lfsr [2];
    int unsigned lfsr_mask;

    initial begin
        int taps [4];
        taps = '{16, 14, 13, 11};
        lfsr_mask = 0;
        foreach (taps[i]) lfsr_mask |= (32'd1 << (taps[i] - 1));
    end

    function automatic longint clampv(input longint v, inout bit hit);
        if (v > LIM)  begin hit = 1'b1; return LIM;  end
        if (v < -LIM) begin hit = 1'b1; return -LIM; end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NCH; k++) begin
                    m_a1[d][k] = 0; m_a2[d][k] = 0; m_p[d][k] = 0; m_o[d][k] = 0;
                end
                m_lfsr[d] = 32'hACE1;
            end
            for (int k = 0; k < NCH; k++) m_hold[k] = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NCH; k++) begin
                    if (if0.pdm_ce) begin
                        longint x, fb, v1, v2;
                        bit hit;
                        hit = 1'b0;
                        x  = if0.mute ? 0 : m_hold[k];
                        if (DITH[d] != 0) x += longint'((m_lfsr[d] >> (k % 16)) & 1);
                        fb = m_p[d][k] ? FS : -FS;
                        v1 = clampv(m_a1[d][k] + x - fb, hit);
                        v2 = 0;
                        if (ORD[d] == 2) v2 = clampv(m_a2[d][k] + v1 - fb, hit);
                        m_a1[d][k] = v1;
                        m_a2[d][k] = v2;
                        m_p[d][k]  = (ORD[d] == 2) ? (v2 >= 0) : (v1 >= 0);
                        if (hit) m_o[d][k] = 1'b1;
                        else if (if0.ovl_clr) m_o[d][k] = 1'b0;
                    end else if (if0.ovl_clr) begin
                        m_o[d][k] = 1'b0;
                    end
                end
                if (if0.pdm_ce) begin
                    m_lfsr[d] = (m_lfsr[d] >> 1) ^ ((m_lfsr[d] & 1) != 0 ? lfsr_mask : 0);
                end
            end
            if (if0.in_valid) begin
                for (int k = 0; k < NCH; k++)
                    m_hold[k] = longint'($signed(if0.in_data[k*DW +: DW]));
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [NCH-1:0] ep, eo, ap, ao;
                for (int k = 0; k < NCH; k++) begin
                    ep[k] = m_p[d][k];
                    eo[k] = m_o[d][k];
                end
                ap = (d == 0) ? if0.pdm : if1.pdm;
                ao = (d == 0) ? if0.ovl : if1.ovl;
                n_chk++;
                if (ap !== ep || ao !== eo) begin
                    n_fail++;
                    if (n_fail < 40)
                        $display("FAIL model_cmp dut%0d t=%0t pdm got=%b exp=%b ovl got=%b exp=%b",
                                 d, $time, ap, ep, ao, eo);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit ce, input bit v, input logic [63:0] data, input bit clr);
        if0.pdm_ce = ce;  if1.pdm_ce = ce;
        if0.in_valid = v; if1.in_valid = v;
        if0.in_data = data; if1.in_data = data;
        if0.mute = mute_r; if1.mute = mute_r;
        if0.ovl_clr = clr; if1.ovl_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic load_dc(input int val);
        logic [15:0] s;
        s = val[15:0];
        cyc(1'b0, 1'b1, {4{s}}, 1'b0);
    endtask

    task automatic run_ce(input int n, output int c0, output int c1);
        c0 = 0; c1 = 0;
        repeat (n) begin
            cyc(1'b1, 1'b0, 64'h0, 1'b0);
            c0 += int'(if0.pdm[0]);
            c1 += int'(if1.pdm[0]);
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        n_chk++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d+/-%0d", name, act, exp, tol);
        end
    endtask

    task automatic check_min(input string name, input int act, input int lo);
        n_chk++;
        if (act < lo) begin
            n_fail++;
            $display("FAIL %s got=%0d exp>=%0d", name, act, lo);
        end
    endtask

    task automatic density(input string tag, input int exp0, input int tol0,
                           input int exp1, input int tol1);
        int c0, c1;
        run_ce(64, c0, c1);
        run_ce(1024, c0, c1);
        check_near({tag, "_o2"}, c0, exp0, tol0);
        check_near({tag, "_o1"}, c1, exp1, tol1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, c1;
        if0.pdm_ce = 0; if0.in_valid = 0; if0.in_data = '0; if0.mute = 0; if0.ovl_clr = 0;
        if1.pdm_ce = 0; if1.in_valid = 0; if1.in_data = '0; if1.mute = 0; if1.ovl_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pdm0", 32'(if0.pdm), 32'h0);
        check_eq("rst_ovl0", 32'(if0.ovl), 32'h0);
        check_eq("rst_pdm1", 32'(if1.pdm), 32'h0);
        check_eq("rst_ovl1", 32'(if1.ovl), 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Zero input from reset: both builds emit 1,1,0 on channel 0
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        check_eq("first_step", {30'h0, if0.pdm[0], if1.pdm[0]}, 32'h3);
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        check_eq("second_step", {30'h0, if0.pdm[0], if1.pdm[0]}, 32'h3);
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        check_eq("third_step", {30'h0, if0.pdm[0], if1.pdm[0]}, 32'h0);
        run_ce(1024, c0, c1);
        check_near("zero_dens_o2", c0, 512, 2);
        check_near("zero_dens_o1", c1, 512, 2);

        load_dc(16384);
        density("pos_half", 768, 4, 768, 2);
        check_eq("pos_half_ovl", {if0.ovl, if1.ovl}, 32'h0);
        load_dc(-16384);
        density("neg_half", 256, 4, 256, 2);
        check_eq("neg_half_ovl", {if0.ovl, if1.ovl}, 32'h0);

        load_dc(16384);
        mute_r = 1'b1;
        density("mute", 512, 4, 512, 4);
        check_eq("mute_ovl", {if0.ovl, if1.ovl}, 32'h0);
        mute_r = 1'b0;

        load_dc(32767);
        run_ce(3072, c0, c1);
        run_ce(1024, c0, c1);
        check_min("fs_dens_o2", c0, 1020);
        check_min("fs_dens_o1", c1, 1020);
        load_dc(0);
        density("fs_step0", 512, 4, 512, 4);

        // Negative full scale from a clean reset: the 2nd-order a2 clamps on step 4 and stays clamped
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_dc(-32768);
        run_ce(8, c0, c1);
        check_eq("negfs_ovl_o2", 32'(if0.ovl), 32'hF);
        check_eq("negfs_ovl_o1", 32'(if1.ovl), 32'h0);
        cyc(1'b1, 1'b0, 64'h0, 1'b1);
        check_eq("clr_vs_set", 32'(if0.ovl), 32'hF);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("clr_idle", 32'(if0.ovl), 32'h0);
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        check_eq("reset_after_clr", 32'(if0.ovl), 32'hF);

        // Asynchronous reset in the middle of a cycle
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_ovl", {if0.ovl, if1.ovl}, 32'h0);
        check_eq("async_rst_pdm", {if0.pdm, if1.pdm}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Sparse clock enable with loads landing on and off enable edges
        for (int i = 0; i < 600; i++) begin
            cyc((i % 4) == 0, $urandom_range(0, 3) == 0,
                {$urandom, $urandom}, $urandom_range(0, 31) == 0);
        end

        // Fully random traffic with distinct per-channel samples
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) mute_r = ~mute_r;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                {$urandom, $urandom}, $urandom_range(0, 31) == 0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
